// File: rtl/pagerank_mapper_ctrl.sv
// Sequencer for one PageRank iteration: fetches rank/weight pairs per destination
// node, feeds the two-lane multiply-add mapper, accumulates, and emits one rank per node.
module pagerank_mapper_ctrl #(
    parameter int nbits  = 32,
    parameter int nnodes = 8,
    parameter int aw     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             req_val,
    input  logic             req_rdy,
    output logic [aw-1:0]    req_row,
    output logic [aw-1:0]    req_col,
    input  logic             resp_val,
    output logic             resp_rdy,
    input  logic [nbits-1:0] resp_r0,
    input  logic [nbits-1:0] resp_r1,
    input  logic [nbits-1:0] resp_g0,
    input  logic [nbits-1:0] resp_g1,
    output logic [nbits-1:0] map_r0,
    output logic [nbits-1:0] map_r1,
    output logic [nbits-1:0] map_g0,
    output logic [nbits-1:0] map_g1,
    input  logic [nbits-1:0] map_out,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [aw-1:0]    out_idx,
    output logic [nbits-1:0] out_data
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        OUT,
        DONE
    } state_t;

    localparam logic [aw-1:0] last_col = aw'(nnodes - 2);
    localparam logic [aw-1:0] last_row = aw'(nnodes - 1);

    state_t           state;
    logic [aw-1:0]    row;
    logic [aw-1:0]    col;
    logic [nbits-1:0] acc;

    // Request and result fields come straight from state registers, so they
    // stay stable across any stall without extra holding logic.
    assign req_row  = row;
    assign req_col  = col;
    assign out_idx  = row;
    assign out_data = acc;

    // Handshake outputs are registered: each transition sets the flags of the
    // state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            map_r0   <= '0;
            map_r1   <= '0;
            map_g0   <= '0;
            map_g1   <= '0;
            req_val  <= 1'b0;
            resp_rdy <= 1'b0;
            out_val  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        row     <= '0;
                        col     <= '0;
                        acc     <= '0;
                        req_val <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (req_rdy) begin
                        req_val  <= 1'b0;
                        resp_rdy <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_val) begin
                        map_r0   <= resp_r0;
                        map_r1   <= resp_r1;
                        map_g0   <= resp_g0;
                        map_g1   <= resp_g1;
                        resp_rdy <= 1'b0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + map_out;
                    if (col == last_col) begin
                        out_val <= 1'b1;
                        state   <= OUT;
                    end else begin
                        col     <= col + aw'(2);
                        req_val <= 1'b1;
                        state   <= REQ;
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
                        if (row == last_row) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row     <= row + aw'(1);
                            col     <= '0;
                            acc     <= '0;
                            req_val <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    req_val  <= 1'b0;
                    resp_rdy <= 1'b0;
                    out_val  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pagerank_mapper_ctrl.sv
// Directed bench for pagerank_mapper_ctrl: memory responder, mapper model and
// an output scoreboard, with stalls, wrap, ignored go/resp_val and async reset.
module tb_pagerank_mapper_ctrl;

    localparam int NB = 32;
    localparam int NN = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          busy, done;
    logic          req_val, req_rdy;
    logic [AW-1:0] req_row, req_col;
    logic          resp_val, resp_rdy;
    logic [NB-1:0] resp_r0, resp_r1, resp_g0, resp_g1;
    logic [NB-1:0] map_r0, map_r1, map_g0, map_g1, map_out;
    logic          out_val, out_rdy;
    logic [AW-1:0] out_idx;
    logic [NB-1:0] out_data;

    pagerank_mapper_ctrl #(.nbits(NB), .nnodes(NN), .aw(AW)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done),
        .req_val(req_val), .req_rdy(req_rdy), .req_row(req_row), .req_col(req_col),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_r0(resp_r0), .resp_r1(resp_r1), .resp_g0(resp_g0), .resp_g1(resp_g1),
        .map_r0(map_r0), .map_r1(map_r1), .map_g0(map_g0), .map_g1(map_g1),
        .map_out(map_out), .out_val(out_val), .out_rdy(out_rdy),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    assign map_out = map_r0 * map_g0 + map_r1 * map_g1;

    int n_tests = 0;
    int n_fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int k = 0;
    int req_stall_n = 0;
    int resp_delay_n = 0;
    int out_stall_n = 0;
    int out_stall_row = -1;
    bit spurious = 1'b0;

    logic [NB-1:0] r_mem [NN];
    logic [NB-1:0] g_mem [NN][NN];
    logic [AW+NB-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] model_row(input int i);
        logic [NB-1:0] s;
        s = '0;
        for (int j = 0; j < NN; j++) s = s + r_mem[j] * g_mem[i][j];
        return s;
    endfunction

    task automatic load_basic();
        r_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
        g_mem[0] = '{32'd1, 32'd1, 32'd1, 32'd1};
        g_mem[1] = '{32'd0, 32'd1, 32'd0, 32'd0};
        g_mem[2] = '{32'd0, 32'd0, 32'd0, 32'd0};
        g_mem[3] = '{32'd2, 32'd0, 32'd0, 32'd1};
    endtask

    task automatic push_basic();
        exp_q.push_back({8'd0, 32'd10});
        exp_q.push_back({8'd1, 32'd2});
        exp_q.push_back({8'd2, 32'd0});
        exp_q.push_back({8'd3, 32'd6});
    endtask

    // Memory responder: request stalls, response delay, optional stray resp_val
    initial begin
        int cnt;
        bit pending;
        logic [AW-1:0] held_row, held_col, p_row, p_col;
        int er, ec;
        cnt = 0;
        pending = 1'b0;
        held_row = '0; held_col = '0; p_row = '0; p_col = '0;
        req_rdy = 1'b0; resp_val = 1'b0;
        resp_r0 = '0; resp_r1 = '0; resp_g0 = '0; resp_g1 = '0;
        forever begin
            @(negedge clk);
            req_rdy = 1'b0;
            resp_val = 1'b0;
            if (reset) begin
                pending = 1'b0;
                cnt = 0;
            end else if (!pending) begin
                if (req_val) begin
                    if (cnt == 0) begin
                        held_row = req_row;
                        held_col = req_col;
                    end else begin
                        check("req_row_stable", req_row, held_row);
                        check("req_col_stable", req_col, held_col);
                    end
                    if (cnt >= req_stall_n) begin
                        er = k / (NN / 2);
                        ec = (k % (NN / 2)) * 2;
                        check("req_row_order", req_row, er);
                        check("req_col_order", req_col, ec);
                        k++;
                        req_rdy = 1'b1;
                        pending = 1'b1;
                        p_row = req_row;
                        p_col = req_col;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (resp_rdy) begin
                if (cnt >= resp_delay_n) begin
                    resp_val = 1'b1;
                    resp_r0 = r_mem[int'(p_col)];
                    resp_r1 = r_mem[int'(p_col) + 1];
                    resp_g0 = g_mem[int'(p_row)][int'(p_col)];
                    resp_g1 = g_mem[int'(p_row)][int'(p_col) + 1];
                    pending = 1'b0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (spurious && !resp_val && !reset && (req_val || out_val)) begin
                resp_val = 1'b1;
                resp_r0 = 32'hDEAD0001;
                resp_r1 = 32'hDEAD0002;
                resp_g0 = 32'hDEAD0003;
                resp_g1 = 32'hDEAD0004;
            end
        end
    end

    // Result consumer and scoreboard
    initial begin
        int ocnt;
        logic [AW-1:0] h_idx;
        logic [NB-1:0] h_data;
        logic [AW+NB-1:0] e;
        ocnt = 0;
        h_idx = '0;
        h_data = '0;
        out_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (out_val && !reset) begin
                if (ocnt == 0) begin
                    h_idx = out_idx;
                    h_data = out_data;
                end else begin
                    check("out_idx_stable", out_idx, h_idx);
                    check("out_data_stable", out_data, h_data);
                end
                if (int'(out_idx) == out_stall_row && ocnt < out_stall_n) begin
                    out_rdy = 1'b0;
                    ocnt++;
                end else begin
                    out_rdy = 1'b1;
                    ocnt = 0;
                    n_tests++;
                    assert (exp_q.size() > 0) else begin
                        n_fails++;
                        $error("FAIL out_unexpected observed=idx%0d,0x%0h expected=no_output", out_idx, out_data);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_idx", out_idx, e[AW+NB-1:NB]);
                        check("out_data", out_data, e[NB-1:0]);
                    end
                end
            end else begin
                out_rdy = 1'b1;
                ocnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic start_go();
        @(negedge clk);
        go = 1'b1;
        start_cyc = cyc;
        k = 0;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_for(input int sel, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            case (sel)
                0: seen = req_val;
                1: seen = resp_rdy;
                2: seen = out_val;
                default: seen = done;
            endcase
            if (seen) break;
        end
        n_tests++;
        assert (seen) else begin
            n_fails++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    task automatic run_iter(input string tag, input bit chk_lat);
        int d0;
        d0 = done_cnt;
        start_go();
        wait_for(3, {tag, "_done"});
        if (chk_lat) check({tag, "_latency"}, cyc - start_cyc, 29);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_done_count"}, done_cnt, d0 + 1);
        check({tag, "_all_outputs"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        bit found;

        // Reset state
        load_basic();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req_val", req_val, 0);
        check("rst_resp_rdy", resp_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_map_r0", map_r0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic iteration, no stalls
        push_basic();
        run_iter("basic", 1'b1);
        check("basic_map_r0", map_r0, 3);
        check("basic_map_r1", map_r1, 4);
        check("basic_map_g0", map_g0, 0);
        check("basic_map_g1", map_g1, 1);

        // Same data with request/response/output stalls
        req_stall_n = 3;
        resp_delay_n = 2;
        out_stall_n = 4;
        out_stall_row = 1;
        push_basic();
        run_iter("stall", 1'b0);
        req_stall_n = 0;
        resp_delay_n = 0;
        out_stall_n = 0;
        out_stall_row = -1;

        // Accumulator wrap: each pair of row 0 returns 0xFFFFFFFF
        r_mem = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0};
        g_mem[0] = '{32'd1, 32'd0, 32'd1, 32'd0};
        exp_q.push_back({8'd0, 32'hFFFFFFFE});
        for (int i = 1; i < NN; i++) exp_q.push_back({AW'(i), model_row(i)});
        run_iter("wrap", 1'b1);

        // go pulses in REQ, WAIT, OUT and DONE must not restart
        load_basic();
        push_basic();
        d0 = done_cnt;
        start_go();
        wait_for(0, "gop_req");
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_for(1, "gop_wait");
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_for(2, "gop_out");
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_for(3, "gop_done");
        go = 1'b1; @(negedge clk); go = 1'b0;
        check("gop_idle_after_done", busy, 0);
        repeat (20) @(negedge clk);
        check("gop_no_restart", busy, 0);
        check("gop_all_outputs", exp_q.size(), 0);
        check("gop_done_count", done_cnt, d0 + 1);

        // Async reset while row 2 waits for its response
        resp_delay_n = 2;
        exp_q.push_back({8'd0, 32'd10});
        exp_q.push_back({8'd1, 32'd2});
        d0 = done_cnt;
        start_go();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_rdy && req_row == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("arst_reach_row2_wait", found, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_req_val", req_val, 0);
        check("arst_resp_rdy", resp_rdy, 0);
        check("arst_out_val", out_val, 0);
        check("arst_done", done, 0);
        check("arst_req_row", req_row, 0);
        check("arst_map_r0", map_r0, 0);
        check("arst_map_g1", map_g1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        resp_delay_n = 0;
        repeat (10) @(negedge clk);
        check("arst_no_partial", exp_q.size(), 0);
        check("arst_no_done", done_cnt, d0);
        check("arst_idle", busy, 0);
        push_basic();
        run_iter("arst_rerun", 1'b1);

        // Stray resp_val in REQ and OUT
        spurious = 1'b1;
        push_basic();
        run_iter("spur", 1'b1);
        spurious = 1'b0;
        check("spur_map_r0", map_r0, 3);
        check("spur_map_r1", map_r1, 4);
        check("spur_map_g0", map_g0, 0);
        check("spur_map_g1", map_g1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/pagerank_mapper_ctrl.md
Name: pagerank_mapper_ctrl

Overview:
Sequencer for one PageRank iteration. It drives the shared two-lane multiply-add mapper, whose output is map_out = r_0*g_0 + r_1*g_1. For each destination node it fetches operand pairs through a val/rdy memory port, presents them to the mapper, and accumulates the mapper result. It then emits one new rank value per node through a val/rdy output port. It sits between the rank/graph memory interface and the mapper datapath.

Parameters:
nbits, 32, data width of ranks, graph weights and accumulator
nnodes, 8, node count; even, 2 to 256
aw, 8, index width for row and column; 2^aw >= nnodes

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
go  input  1  start one iteration; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the iteration completes
req_val  output  1  memory read request valid
req_rdy  input  1  memory accepts request
req_row  output  aw  destination node index i
req_col  output  aw  even source index j; the request covers j and j+1
resp_val  input  1  memory response valid
resp_rdy  output  1  controller accepts response
resp_r0  input  nbits  r[j]
resp_r1  input  nbits  r[j+1]
resp_g0  input  nbits  g[i][j]
resp_g1  input  nbits  g[i][j+1]
map_r0  output  nbits  mapper operand r_0 (registered)
map_r1  output  nbits  mapper operand r_1 (registered)
map_g0  output  nbits  mapper operand g_0 (registered)
map_g1  output  nbits  mapper operand g_1 (registered)
map_out  input  nbits  mapper result (combinational from map_*)
out_val  output  1  result valid
out_rdy  input  1  consumer ready
out_idx  output  aw  node index of result
out_data  output  nbits  accumulated rank for out_idx

Behaviour:
- Reset (asynchronous, any state): state=IDLE; row, col, acc and all map_* = 0. All outputs 0: req_val, resp_rdy, out_val, busy, done. An iteration in flight is abandoned, with no partial output.
- FSM states: IDLE, REQ, WAIT, ACC, OUT, DONE.
- IDLE: on go=1, set row=0, col=0, acc=0 and go to REQ.
- REQ: req_val=1 with req_row=row, req_col=col. On req_rdy, go to WAIT. req_row and req_col are held stable while req_val=1 and req_rdy=0.
- WAIT: resp_rdy=1. On resp_val, latch resp_r0, resp_r1, resp_g0, resp_g1 into map_r0, map_r1, map_g0, map_g1 and go to ACC.
- ACC: acc <= acc + map_out.
  - If col == nnodes-2, go to OUT.
  - Otherwise col <= col+2 and go to REQ.
- OUT: out_val=1, out_idx=row, out_data=acc, all held stable until out_rdy.
  - On out_rdy with row == nnodes-1, go to DONE.
  - On out_rdy otherwise, row <= row+1, col=0, acc=0, go to REQ.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the same cycle as the return to IDLE.
- Only one memory request is outstanding at a time. resp_val outside WAIT is ignored (not an error).
- Arithmetic: the accumulator is nbits wide and wraps modulo 2^nbits. There is no saturation and no scaling; damping is applied downstream.
- go is ignored in every state other than IDLE. A go arriving in the DONE cycle is not captured.
- Latency: with all ready/valid signals held high, each pair costs 3 cycles (REQ, WAIT, ACC) and each row adds 1 OUT cycle. An iteration therefore takes nnodes*(3*nnodes/2 + 1) + 1 cycles from go to done.
- map_* keep their last values between pairs and in IDLE.
- out_data is exactly the acc register; no combinational path from map_out to any output.

Test Plan:
- nnodes=4, r=[1,2,3,4], g row0=[1,1,1,1], row1=[0,1,0,0], row2=[0,0,0,0], row3=[2,0,0,1] -> outputs (0,10),(1,2),(2,0),(3,6) in order; done pulses once; 29 cycles go-to-done with no stalls.
- Same data with req_rdy low 3 cycles and resp_val delayed 2 cycles per pair, out_rdy low 4 cycles on row 1 -> identical values; req_row/req_col and out_idx/out_data stable throughout each stall.
- Wrap: a row where the mapper returns 0xFFFFFFFF for both pairs (nnodes=4) -> out_data=0xFFFFFFFE.
- go pulsed in REQ, WAIT, OUT and DONE -> no restart; exactly nnodes outputs and one done per accepted go.
- Reset asserted mid-row 2 in WAIT, asynchronously between edges -> outputs drop to 0 immediately, no further out_val. A following go runs a full clean iteration from row 0 with acc=0.
- Spurious resp_val in REQ and OUT -> ignored; map_* unchanged; results match the first scenario.
